// File: rtl/clockworks_pkg.sv
// clockworks_pkg: shared constants and helpers for the clock gearbox / reset
// generator slice.
//   SLOW_DEFAULT        default divider exponent (clk = CLK / 2^SLOW)
//   RST_HOLD_DEFAULT    default extra clk cycles resetn stays low after release
//   BTN_ACTLOW_DEFAULT  default reset button polarity (0 = active-high pin)
//   hold_cnt_width()    width of the reset hold counter for a given hold length
package clockworks_pkg;

  localparam int unsigned SLOW_DEFAULT       = 21;
  localparam int unsigned RST_HOLD_DEFAULT   = 15;
  localparam bit          BTN_ACTLOW_DEFAULT = 1'b0;

  // $clog2(hold+1) collapses to 0 bits when hold is 0; keep one bit so the
  // counter stays a legal vector (it then simply sits at 0 forever).
  function automatic int unsigned hold_cnt_width(input int unsigned hold);
    return (hold == 0) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/clockworks_sync2.sv
// clockworks_sync2: 1-bit two-flop synchronizer, both flops power up at 0.
// No reset input: it sits in front of the reset generator itself.
//   clk_i  destination clock
//   d_i    asynchronous input
//   q_o    synchronized output (two clk_i edges of latency)
module clockworks_sync2 (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q = 1'b0;
  logic sync_q = 1'b0;

  always_ff @(posedge clk_i) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/clockworks.sv
// clockworks: clock gearbox and reset generator at the top of the SoC.
// Divides the board clock by 2^SLOW (SLOW = 0 passes CLK straight through)
// and turns the raw reset button into a clean, clk-synchronous active-low
// reset with a power-up / post-release hold of RST_HOLD clk cycles.
//   CLK     board oscillator, the only primary clock
//   RESET   raw reset button (asynchronous, not debounced), polarity BTN_ACTLOW
//   clk     derived SoC clock, 50% duty, starts low
//   resetn  synchronous active-low reset, registered on posedge clk
module clockworks
  import clockworks_pkg::*;
#(
  parameter int unsigned SLOW       = SLOW_DEFAULT,
  parameter int unsigned RST_HOLD   = RST_HOLD_DEFAULT,
  parameter bit          BTN_ACTLOW = BTN_ACTLOW_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  output logic clk,
  output logic resetn
);

  // ---------------------------------------------------------------------------
  // Divider: free-running, never reset, so clk keeps running through reset.
  // ---------------------------------------------------------------------------
  generate
    if (SLOW > 0) begin : g_div
      logic [SLOW-1:0] div_cnt_q = '0;

      always_ff @(posedge CLK) begin
        div_cnt_q <= div_cnt_q + SLOW'(1);
      end

      assign clk = div_cnt_q[SLOW-1];
    end else begin : g_pass
      assign clk = CLK;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Reset path, entirely in the clk domain.
  // ---------------------------------------------------------------------------
  localparam int unsigned     HW       = hold_cnt_width(RST_HOLD);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(RST_HOLD);

  logic          btn_raw;
  logic          btn_sync;
  logic [HW-1:0] hold_q = '0;
  logic [HW-1:0] hold_d;
  logic          resetn_q = 1'b0;
  logic          resetn_d;

  // 1 = button pressed, independent of pin polarity.
  assign btn_raw = RESET ^ BTN_ACTLOW;

  clockworks_sync2 u_sync (
    .clk_i (clk),
    .d_i   (btn_raw),
    .q_o   (btn_sync)
  );

  // A press clears the hold; release lets it count up and saturate. resetn is
  // only released once the count has saturated with the button still up, so a
  // re-press during the hold restarts the whole wait.
  always_comb begin
    hold_d = hold_q;
    if (btn_sync) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HW'(1);
    end
    resetn_d = (hold_q == HOLD_MAX) && !btn_sync;
  end

  always_ff @(posedge clk) begin
    hold_q   <= hold_d;
    resetn_q <= resetn_d;
  end

  assign resetn = resetn_q;

endmodule

// File: tb/tb_clockworks.sv
// tb_clockworks: randomized self-checking bench for clockworks.
// Four instances cover the main configuration (SLOW=2, RST_HOLD=3), the
// pass-through clock (SLOW=0), the active-low button pin, and RST_HOLD=0.
module tb_clockworks;

  bit   CLK = 1'b0;
  logic btn_a = 1'b0;  // SLOW=2 RST_HOLD=3 active-high
  logic btn_b = 1'b0;  // SLOW=0 RST_HOLD=3 active-high
  logic btn_c = 1'b1;  // SLOW=2 RST_HOLD=3 active-low (idle = 1)
  logic btn_d = 1'b0;  // SLOW=1 RST_HOLD=0 active-high
  logic clk_a, clk_b, clk_c, clk_d;
  logic rstn_a, rstn_b, rstn_c, rstn_d;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 CLK = ~CLK;

  clockworks #(.SLOW(2), .RST_HOLD(3), .BTN_ACTLOW(1'b0)) u_a (
    .CLK(CLK), .RESET(btn_a), .clk(clk_a), .resetn(rstn_a));
  clockworks #(.SLOW(0), .RST_HOLD(3), .BTN_ACTLOW(1'b0)) u_b (
    .CLK(CLK), .RESET(btn_b), .clk(clk_b), .resetn(rstn_b));
  clockworks #(.SLOW(2), .RST_HOLD(3), .BTN_ACTLOW(1'b1)) u_c (
    .CLK(CLK), .RESET(btn_c), .clk(clk_c), .resetn(rstn_c));
  clockworks #(.SLOW(1), .RST_HOLD(0), .BTN_ACTLOW(1'b0)) u_d (
    .CLK(CLK), .RESET(btn_d), .clk(clk_d), .resetn(rstn_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge CLK);
  endtask

  // Reference: h[k-1] is the "pressed" value seen at clk edge k (edges count
  // from 1, anything before power-up reads as not pressed). After edge n,
  // resetn is high only once power-up has lasted hold+1 edges and the window of
  // hold+1 samples ending two edges back (synchronizer delay) is all released.
  function automatic bit exp_rstn(input bit h[$], input int n, input int hold);
    if (n < hold + 1) return 1'b0;
    for (int k = n - 2 - hold; k <= n - 2; k++)
      if (k >= 1 && h[k-1]) return 1'b0;
    return 1'b1;
  endfunction

  int na = 0, nb = 0, nc = 0, nd = 0;
  bit ha[$], hb[$], hc[$], hd[$];

  always @(posedge clk_a) begin na++; ha.push_back(btn_a); end
  always @(posedge clk_b) begin nb++; hb.push_back(btn_b); end
  always @(posedge clk_c) begin nc++; hc.push_back(~btn_c); end
  always @(posedge clk_d) begin nd++; hd.push_back(btn_d); end

  always @(negedge clk_a) if (na > 0) check("rstn_a", rstn_a, exp_rstn(ha, na, 3));
  always @(negedge clk_b) if (nb > 0) check("rstn_b", rstn_b, exp_rstn(hb, nb, 3));
  always @(negedge clk_c) if (nc > 0) check("rstn_c", rstn_c, exp_rstn(hc, nc, 3));
  always @(negedge clk_d) if (nd > 0) check("rstn_d", rstn_d, exp_rstn(hd, nd, 0));

  // Divider reference: after m CLK rising edges a 2^s divider output is high
  // for the upper half of each 2^s window; it never pauses for reset.
  int unsigned ncyc = 0;
  always @(posedge CLK) ncyc++;

  always @(negedge CLK) begin
    if (ncyc > 0) begin
      check("clk_a", clk_a, 32'((ncyc % 4) >= 2));
      check("clk_c", clk_c, 32'((ncyc % 4) >= 2));
      check("clk_d", clk_d, 32'(ncyc % 2));
      check("clk_b_lo", clk_b, 32'd0);
    end
  end

  always @(posedge CLK) begin
    #1;
    check("clk_b_hi", clk_b, 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    check("por_rstn_a", rstn_a, 32'd0);
    check("por_rstn_b", rstn_b, 32'd0);
    check("por_rstn_c", rstn_c, 32'd0);
    check("por_rstn_d", rstn_d, 32'd0);
    check("por_clk_a", clk_a, 32'd0);
    check("por_clk_c", clk_c, 32'd0);
    check("por_clk_d", clk_d, 32'd0);

    // Let every instance finish its power-up hold with the button idle.
    @(negedge CLK);
    wait_clk(40);
    check("pu_rstn_a", rstn_a, 32'd1);
    check("pu_rstn_b", rstn_b, 32'd1);
    check("pu_rstn_c", rstn_c, 32'd1);
    check("pu_rstn_d", rstn_d, 32'd1);

    fork
      begin
        // 3-period press, long release.
        btn_a = 1'b1; wait_clk(12);
        btn_a = 1'b0; wait_clk(40);
        // Re-press during the hold period.
        btn_a = 1'b1; wait_clk(8);
        btn_a = 1'b0; wait_clk(8);
        btn_a = 1'b1; wait_clk(8);
        btn_a = 1'b0; wait_clk(40);
        // Long press: clock keeps running for 64 CLK cycles under reset.
        btn_a = 1'b1; wait_clk(64);
        btn_a = 1'b0; wait_clk(40);
        for (int i = 0; i < 30; i++) begin
          btn_a = ~btn_a;
          wait_clk($urandom_range(1, 40));
        end
        btn_a = 1'b0;
      end
      begin
        btn_b = 1'b1; wait_clk(3);
        btn_b = 1'b0; wait_clk(12);
        for (int i = 0; i < 40; i++) begin
          btn_b = ~btn_b;
          wait_clk($urandom_range(1, 12));
        end
        btn_b = 1'b0;
      end
      begin
        btn_c = 1'b0; wait_clk(12);
        btn_c = 1'b1; wait_clk(40);
        for (int i = 0; i < 30; i++) begin
          btn_c = ~btn_c;
          wait_clk($urandom_range(1, 40));
        end
        btn_c = 1'b1;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          btn_d = ~btn_d;
          wait_clk($urandom_range(1, 10));
        end
        btn_d = 1'b0;
      end
    join

    // Idle long enough for every instance to come out of reset again.
    wait_clk(60);
    check("end_rstn_a", rstn_a, 32'd1);
    check("end_rstn_b", rstn_b, 32'd1);
    check("end_rstn_c", rstn_c, 32'd1);
    check("end_rstn_d", rstn_d, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
